// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries dispatch at the tail, complete out of order
// via the CDB, retire from the head, and unwind tail-first on a flush.
module reorder_buffer #(
   parameter int ROB_DEPTH = 8,
   parameter int PREG_W    = 5,
   localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dispatch_valid,
   input  logic              dispatch_has_dest,
   input  logic [4:0]        dispatch_arch_dest,
   input  logic [PREG_W-1:0] dispatch_phys_dest,
   input  logic [PREG_W-1:0] dispatch_dest_old,
   output logic              dispatch_ready,
   output logic [TAG_W-1:0]  dispatch_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic              flush,
   output logic              retire_valid,
   output logic [4:0]        retire_arch_dest,
   output logic [PREG_W-1:0] retire_phys_dest,
   output logic              commit_flag,
   output logic [PREG_W-1:0] commit_phys_reg,
   output logic              squashing
);

   // Handshake: a dispatch is accepted on a rising edge only when dispatch_valid
   // and dispatch_ready are both high; dispatch_ready never depends on dispatch_valid.

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(ROB_DEPTH);
   localparam logic [TAG_W:0] ONE  = (TAG_W+1)'(1);

   state_t state, state_nxt;

   logic [TAG_W-1:0]  head, tail, tail_dec;
   logic [TAG_W:0]    count;
   logic [ROB_DEPTH-1:0] ent_valid, ent_done, ent_has_dest;
   logic [4:0]        ent_arch [ROB_DEPTH];
   logic [PREG_W-1:0] ent_phys [ROB_DEPTH];
   logic [PREG_W-1:0] ent_old  [ROB_DEPTH];

   logic run_ok, do_dispatch, do_retire, do_cdb, do_squash;

   // A flush edge in RUN drops every other request, even with an empty buffer.
   assign run_ok      = (state == RUN) && !flush;
   assign do_dispatch = run_ok && dispatch_valid && dispatch_ready;
   assign do_retire   = run_ok && (count != '0) && ent_valid[head] && ent_done[head];
   assign do_cdb      = run_ok && cdb_valid && ent_valid[cdb_tag];
   assign do_squash   = (state == SQUASH);
   assign tail_dec    = tail - TAG_W'(1);
   assign dispatch_tag = tail;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush && (count != '0)) state_nxt = SQUASH;
         SQUASH:  if (count == ONE) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      squashing      = (state == SQUASH);
      dispatch_ready = (state == RUN) && (count < FULL);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         ent_valid        <= '0;
         ent_done         <= '0;
         ent_has_dest     <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            ent_arch[i] <= '0;
            ent_phys[i] <= '0;
            ent_old[i]  <= '0;
         end
         retire_valid     <= 1'b0;
         retire_arch_dest <= '0;
         retire_phys_dest <= '0;
         commit_flag      <= 1'b0;
         commit_phys_reg  <= '0;
      end else begin
         retire_valid <= 1'b0;
         commit_flag  <= 1'b0;
         if (do_squash) begin
            // Youngest first: hand the speculative allocation back to the free list.
            tail                <= tail_dec;
            count               <= count - ONE;
            ent_valid[tail_dec] <= 1'b0;
            ent_done[tail_dec]  <= 1'b0;
            commit_flag         <= ent_has_dest[tail_dec];
            commit_phys_reg     <= ent_phys[tail_dec];
         end else begin
            if (do_cdb) ent_done[cdb_tag] <= 1'b1;
            if (do_dispatch) begin
               ent_valid[tail]    <= 1'b1;
               ent_done[tail]     <= 1'b0;
               ent_has_dest[tail] <= dispatch_has_dest;
               ent_arch[tail]     <= dispatch_arch_dest;
               ent_phys[tail]     <= dispatch_phys_dest;
               ent_old[tail]      <= dispatch_dest_old;
               tail               <= tail + TAG_W'(1);
            end
            if (do_retire) begin
               ent_valid[head]  <= 1'b0;
               ent_done[head]   <= 1'b0;
               head             <= head + TAG_W'(1);
               retire_valid     <= 1'b1;
               retire_arch_dest <= ent_arch[head];
               retire_phys_dest <= ent_phys[head];
               commit_flag      <= ent_has_dest[head];
               commit_phys_reg  <= ent_old[head];
            end
            case ({do_dispatch, do_retire})
               2'b10:   count <= count + ONE;
               2'b01:   count <= count - ONE;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 8, entry count, power of two >= 2; TAG_W = log2(ROB_DEPTH).
REQ-002 SHALL have parameter PREG_W, default 5, physical register index width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dispatch_valid  in  1  new instruction from decoder/rename.
REQ-006 SHALL have port dispatch_has_dest  in  1  instruction writes a register.
REQ-007 SHALL have port dispatch_arch_dest  in  5  architectural destination.
REQ-008 SHALL have port dispatch_phys_dest  in  PREG_W  newly allocated physical destination.
REQ-009 SHALL have port dispatch_dest_old  in  PREG_W  previous mapping of the destination.
REQ-010 SHALL have port dispatch_ready  out  1  entry available; accept only when valid&ready.
REQ-011 SHALL have port dispatch_tag  out  TAG_W  tail index to be assigned to this dispatch.
REQ-012 SHALL have port cdb_valid  in  1  completion broadcast.
REQ-013 SHALL have port cdb_tag  in  TAG_W  completing entry.
REQ-014 SHALL have port flush  in  1  squash all in-flight entries (mispredict or exception).
REQ-015 SHALL have port retire_valid  out  1  one-cycle pulse, head entry retired.
REQ-016 SHALL have port retire_arch_dest  out  5  architectural destination of the retired entry.
REQ-017 SHALL have port retire_phys_dest  out  PREG_W  physical destination of the retired entry.
REQ-018 SHALL have port commit_flag  out  1  return request to the free list, one register per cycle.
REQ-019 SHALL have port commit_phys_reg  out  PREG_W  register returned to the free list.
REQ-020 SHALL have port squashing  out  1  high while in SQUASH state.

Function
REQ-021 SHALL hold a circular buffer with head, tail and count (0..ROB_DEPTH); entry = {valid, done, has_dest, arch_dest, phys_dest, dest_old}.
REQ-022 SHALL drive dispatch_ready = (state==RUN) && (count < ROB_DEPTH), using the current count; a same-cycle retire SHALL NOT free a slot for a same-cycle dispatch.
REQ-023 SHALL write an accepted dispatch at tail with done=0, then tail = (tail+1) mod ROB_DEPTH (wrap) and count+1.
REQ-024 SHALL set done on the entry at cdb_tag when cdb_valid is high and that entry is valid; a cdb_tag addressing an invalid entry SHALL be ignored.
REQ-025 SHALL retire at most one entry per cycle, in order: at an edge where state==RUN, count>0 and head entry done=1, it SHALL clear the entry, advance head (wrap) and decrement count.
REQ-026 SHALL register all retire outputs: after a retiring edge, retire_valid=1, retire_arch_dest/retire_phys_dest = entry fields, and commit_flag=has_dest with commit_phys_reg=dest_old, for exactly one cycle.
REQ-027 SHALL require cdb completion one edge before retire: cdb at edge E sets done; retire at edge E+1 at the earliest.
REQ-028 SHALL allow dispatch and retire on the same edge; count then stays unchanged.
REQ-029 SHALL implement FSM RUN and SQUASH; flush at an edge in RUN with count>0 -> SQUASH; with count==0 -> remain RUN with no action.
REQ-030 SHALL give flush priority over dispatch, retire and cdb on the flush edge; all three are dropped.
REQ-031 SHALL, in SQUASH, per edge: tail = tail-1 (wrap), invalidate that entry, count-1, and register commit_flag=has_dest, commit_phys_reg=phys_dest (the squashed allocation); retire_valid stays 0.
REQ-032 SHALL return SQUASH -> RUN on the edge where count reaches 0; squashing=1 for exactly the count-at-flush cycles.
REQ-033 SHALL ignore cdb_valid, dispatch_valid and flush while in SQUASH.
REQ-034 SHALL keep commit_flag, retire_valid and squashing low in any cycle without a retire or squash return.

Reset
REQ-035 SHALL, on reset=0 (asynchronous), clear head, tail, count and all valid/done bits, set state=RUN, and set every registered output to 0; dispatch_ready=1 and dispatch_tag=0 after release.
REQ-036 SHALL abort an in-progress SQUASH on reset without emitting any further returns.

Verification
REQ-037 Dispatch A (dest r3, phys 7, old 3) at edge 0, cdb tag 0 at edge 1 -> retire_valid=1, retire_arch_dest=3, commit_flag=1, commit_phys_reg=3 after edge 2.
REQ-038 Dispatch 8 entries without completion -> dispatch_ready=0, count=8; 9th dispatch_valid ignored; a cdb on tag 0 then frees one slot after its retire.
REQ-039 Complete tag 1 before tag 0 -> no retire until tag 0 completes; then tag 0 and tag 1 retire on consecutive cycles.
REQ-040 Dispatch entries with no dest -> retire_valid=1, commit_flag=0.
REQ-041 Three entries (phys 9, 10, 11) in flight plus a flush -> squashing=1 for 3 cycles; commit_phys_reg=11, 10, 9 in that order; then RUN, dispatch_ready=1, tail=head.
REQ-042 Run 20 dispatch/retire pairs so head and tail wrap past index 7 -> in-order retire, count correct; assert reset mid-SQUASH -> all outputs 0 immediately.
